sram_port_arbiter: RTL and testbench

- Shares the single input/output SRAM access path between two requesters.
- Requester 0 is the binary-convolution engine; requester 1 is the host/image loader.
- Grants one beat (read or write) per cycle using round-robin, with locked bursts capped for fairness.
- Drives registered SRAM address/data/enable and routes read data back to the requester that issued the read, via a latency-matched tag pipe.

---
 rtl/conv_pkg.sv | 19 +
 rtl/rr_grant2.sv | 38 +++
 rtl/sram_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the SRAM port arbiter: default widths, requester ids
// and the one-hot arbitration states.
package conv_pkg;

  localparam int AW_DEFAULT        = 12;
  localparam int DW_DEFAULT        = 16;
  localparam int MAX_BURST_DEFAULT = 16;
  localparam int RD_LAT_DEFAULT    = 1;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_OWN0 = 3'b010,
    S_OWN1 = 3'b100
  } arb_state_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant; the pointer moves to the other side on every
// accepted beat, or is forced when a locked burst is cut short.
module rr_grant2
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       force_en,
  input  logic       force_ptr,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || ptr == ID_REQ0)) begin
      grant[0] = 1'b1;
    end else if (req[1]) begin
      grant[1] = 1'b1;
    end
  end

  // A real grant always wins over a forced pointer value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= ID_REQ0;
    end else if (grant[0]) begin
      ptr <= ID_REQ1;
    end else if (grant[1]) begin
      ptr <= ID_REQ0;
    end else if (force_en) begin
      ptr <= force_ptr;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between the convolution engine (0) and the host loader (1):
// one beat per cycle, round-robin with capped locked bursts, read data routed by tag.
module sram_port_arbiter
  import conv_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int RD_LAT    = RD_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic          req0_lock,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic          req1_lock,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic [AW-1:0] sram_read_address,
  output logic [AW-1:0] sram_write_address,
  output logic [DW-1:0] sram_write_data,
  output logic          sram_write_enable,
  input  logic [DW-1:0] sram_read_data,
  output logic [1:0]    owner
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  arb_state_t    state, state_next;
  logic [CW-1:0] beat_cnt, beat_cnt_next;
  logic [1:0]    rr_req, grant;
  logic          preempt, preempt_ptr;
  logic          accept, acc_we, rd_accept;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [RD_LAT:0] tag_valid, tag_id;

  // While a side owns the port, the other side's request is hidden from the arbiter.
  always_comb begin
    rr_req = {req1_valid, req0_valid};
    if (state == S_OWN0) begin
      rr_req = {1'b0, req0_valid};
    end else if (state == S_OWN1) begin
      rr_req = {req1_valid, 1'b0};
    end
  end

  rr_grant2 u_rr_grant2 (
    .clk       (clk),
    .reset     (reset),
    .req       (rr_req),
    .force_en  (preempt),
    .force_ptr (preempt_ptr),
    .grant     (grant)
  );

  assign req0_ready = grant[0] & ~reset;
  assign req1_ready = grant[1] & ~reset;

  assign accept    = |grant;
  assign acc_we    = grant[1] ? req1_we    : req0_we;
  assign acc_addr  = grant[1] ? req1_addr  : req0_addr;
  assign acc_wdata = grant[1] ? req1_wdata : req0_wdata;
  assign rd_accept = accept & ~acc_we;

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    preempt       = 1'b0;
    preempt_ptr   = ID_REQ0;
    if (grant[0]) begin
      if (req0_lock) begin
        state_next    = S_OWN0;
        beat_cnt_next = (state != S_OWN0) ? CW'(1) :
                        (beat_cnt == MAX_CNT) ? beat_cnt : beat_cnt + CW'(1);
      end else begin
        state_next    = S_IDLE;
        beat_cnt_next = '0;
      end
    end else if (grant[1]) begin
      if (req1_lock) begin
        state_next    = S_OWN1;
        beat_cnt_next = (state != S_OWN1) ? CW'(1) :
                        (beat_cnt == MAX_CNT) ? beat_cnt : beat_cnt + CW'(1);
      end else begin
        state_next    = S_IDLE;
        beat_cnt_next = '0;
      end
    end
    // A saturated burst yields as soon as the other side is waiting, lock or not.
    if (beat_cnt_next >= MAX_CNT &&
        ((state_next == S_OWN0 && req1_valid) || (state_next == S_OWN1 && req0_valid))) begin
      preempt       = 1'b1;
      preempt_ptr   = (state_next == S_OWN0) ? ID_REQ1 : ID_REQ0;
      state_next    = S_IDLE;
      beat_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  always_comb begin
    owner = 2'b00;
    case (state)
      S_OWN0:  owner = 2'b01;
      S_OWN1:  owner = 2'b10;
      default: owner = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_read_address  <= '0;
      sram_write_address <= '0;
      sram_write_data    <= '0;
      sram_write_enable  <= 1'b0;
    end else begin
      sram_write_enable <= 1'b0;
      if (accept) begin
        if (acc_we) begin
          sram_write_address <= acc_addr;
          sram_write_data    <= acc_wdata;
          sram_write_enable  <= 1'b1;
        end else begin
          sram_read_address <= acc_addr;
        end
      end
    end
  end

  // Tag pipe: one stage for the address register plus RD_LAT stages of SRAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[RD_LAT-1:0], rd_accept};
      tag_id    <= {tag_id[RD_LAT-1:0], grant[1]};
    end
  end

  assign rsp0_valid = tag_valid[RD_LAT] & (tag_id[RD_LAT] == ID_REQ0);
  assign rsp1_valid = tag_valid[RD_LAT] & (tag_id[RD_LAT] == ID_REQ1);
  assign rsp0_rdata = rsp0_valid ? sram_read_data : '0;
  assign rsp1_rdata = rsp1_valid ? sram_read_data : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a one-cycle-latency SRAM model;
// unwritten locations read back as 16'hC000 | address.
module tb_sram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_ready, req0_we, req0_lock;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we, req1_lock;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic [AW-1:0] sram_read_address, sram_write_address;
  logic [DW-1:0] sram_write_data, sram_read_data;
  logic          sram_write_enable;
  logic [1:0]    owner;

  int tests_run  = 0;
  int fail_count = 0;
  int proto_viol = 0;
  logic pend0 = 1'b0;
  logic pend1 = 1'b0;

  logic [DW-1:0] mem [4096];
  logic [4095:0] written;

  sram_port_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .req0_valid         (req0_valid),
    .req0_ready         (req0_ready),
    .req0_we            (req0_we),
    .req0_lock          (req0_lock),
    .req0_addr          (req0_addr),
    .req0_wdata         (req0_wdata),
    .rsp0_valid         (rsp0_valid),
    .rsp0_rdata         (rsp0_rdata),
    .req1_valid         (req1_valid),
    .req1_ready         (req1_ready),
    .req1_we            (req1_we),
    .req1_lock          (req1_lock),
    .req1_addr          (req1_addr),
    .req1_wdata         (req1_wdata),
    .rsp1_valid         (rsp1_valid),
    .rsp1_rdata         (rsp1_rdata),
    .sram_read_address  (sram_read_address),
    .sram_write_address (sram_write_address),
    .sram_write_data    (sram_write_data),
    .sram_write_enable  (sram_write_enable),
    .sram_read_data     (sram_read_data),
    .owner              (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      written <= '0;
    end else if (sram_write_enable) begin
      mem[sram_write_address]     <= sram_write_data;
      written[sram_write_address] <= 1'b1;
    end
    sram_read_data <= written[sram_read_address] ? mem[sram_read_address]
                                                 : (16'hC000 | {4'h0, sram_read_address});
  end

  // Requester protocol: a locked, waiting request keeps valid up; readies never overlap.
  always @(negedge clk) begin
    if (!reset && ((pend0 && !req0_valid) || (pend1 && !req1_valid) || (req0_ready && req1_ready)))
      proto_viol <= proto_viol + 1;
    pend0 <= !reset && req0_valid && !req0_ready && req0_lock;
    pend1 <= !reset && req1_valid && !req1_ready && req1_lock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    #1;
    tests_run++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, sram_write_enable} !== 5'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, sram_write_enable});
    end
    tests_run++;
    if (sram_read_address !== 12'h000 || sram_write_address !== 12'h000 || sram_write_data !== 16'h0000) begin
      fail_count++;
      $display("[TB] FAIL reset_sram_regs: got ra=%h wa=%h wd=%h expected all zero",
               sram_read_address, sram_write_address, sram_write_data);
    end
    tests_run++;
    if (owner !== 2'b00) begin
      fail_count++;
      $display("[TB] FAIL reset_owner: got %b expected 00", owner);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    req0_valid = 1'b1; req0_addr = 12'h005;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL single_ready: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
    end
    tick();
    clear_inputs();
    #1;
    tests_run++;
    if (sram_read_address !== 12'h005 || sram_write_enable !== 1'b0 || rsp0_valid !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL single_addr: got ra=%h we=%b rv0=%b expected ra=005 we=0 rv0=0",
               sram_read_address, sram_write_enable, rsp0_valid);
    end
    tick();
    #1;
    tests_run++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 16'hC005 || rsp1_valid !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL single_rsp: got rv0=%b rd0=%h rv1=%b expected rv0=1 rd0=c005 rv1=0",
               rsp0_valid, rsp0_rdata, rsp1_valid);
    end
    tick();
    #1;
    tests_run++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL single_rsp_end: got rv0=%b rv1=%b expected 0 0", rsp0_valid, rsp1_valid);
    end
  endtask

  task automatic test_alternate();
    logic exp0;
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h020; req0_wdata = 16'h1111;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 12'h021; req1_wdata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2) == 0;
      #1;
      tests_run++;
      if (req0_ready !== exp0 || req1_ready !== ~exp0) begin
        fail_count++;
        $display("[TB] FAIL alt_grant%0d: got r0=%b r1=%b expected r0=%b r1=%b",
                 i, req0_ready, req1_ready, exp0, ~exp0);
      end
      tick();
      #1;
      tests_run++;
      if (sram_write_enable !== 1'b1 || sram_write_address !== (exp0 ? 12'h020 : 12'h021) ||
          sram_write_data !== (exp0 ? 16'h1111 : 16'h2222)) begin
        fail_count++;
        $display("[TB] FAIL alt_write%0d: got we=%b wa=%h wd=%h expected we=1 wa=%h wd=%h",
                 i, sram_write_enable, sram_write_address, sram_write_data,
                 exp0 ? 12'h020 : 12'h021, exp0 ? 16'h1111 : 16'h2222);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_burst_preempt();
    int b0, b1, cyc, k;
    int gnt_hist [64];
    logic [1:0]  own_hist [64];
    logic [11:0] wa_hist  [64];
    b0 = 0; b1 = 0; cyc = 0; k = -1;
    do_reset();
    while (cyc < 64 && !(b0 == 20 && b1 == 2)) begin
      req0_valid = (b0 < 20); req0_we = 1'b1; req0_lock = (b0 < 19);
      req0_addr = 12'h040 + 12'(b0); req0_wdata = 16'h4000 + 16'(b0);
      req1_valid = (b1 < 2); req1_we = 1'b1; req1_lock = (b1 < 1);
      req1_addr = 12'h080 + 12'(b1); req1_wdata = 16'h8000 + 16'(b1);
      #1;
      gnt_hist[cyc] = req0_ready ? 1 : (req1_ready ? 2 : 0);
      own_hist[cyc] = owner;
      wa_hist[cyc]  = sram_write_address;
      if (req0_ready) b0++;
      if (req1_ready) b1++;
      tick();
      cyc++;
    end
    clear_inputs();
    tests_run++;
    if (b0 != 20 || b1 != 2) begin
      fail_count++;
      $display("[TB] FAIL burst_done: got b0=%0d b1=%0d after %0d cycles expected 20 2", b0, b1, cyc);
    end
    for (int i = cyc - 1; i >= 0; i--) if (gnt_hist[i] == 2) k = i;
    tests_run++;
    if (k != 16) begin
      fail_count++;
      $display("[TB] FAIL burst_handover: got first req1 grant at cycle %0d expected 16", k);
    end else begin
      tests_run++;
      if (own_hist[0] !== 2'b00 || own_hist[15] !== 2'b01 || own_hist[16] !== 2'b00 || own_hist[17] !== 2'b10) begin
        fail_count++;
        $display("[TB] FAIL burst_owner: got %b %b %b %b expected 00 01 00 10",
                 own_hist[0], own_hist[15], own_hist[16], own_hist[17]);
      end
      tests_run++;
      if (gnt_hist[17] != 2 || gnt_hist[18] != 1) begin
        fail_count++;
        $display("[TB] FAIL burst_resume: got grants %0d %0d expected 2 1", gnt_hist[17], gnt_hist[18]);
      end
      tests_run++;
      if (wa_hist[16] !== 12'h04F || wa_hist[17] !== 12'h080) begin
        fail_count++;
        $display("[TB] FAIL burst_waddr: got %h %h expected 04f 080", wa_hist[16], wa_hist[17]);
      end
    end
    tick();
  endtask

  task automatic test_gap();
    int b0, b1;
    logic exp_r0, exp_r1, exp_v1;
    logic [1:0] exp_own;
    b0 = 0; b1 = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req0_valid = (c < 2 || c >= 5) && (b0 < 5); req0_we = 1'b1; req0_lock = (b0 < 4);
      req0_addr = 12'h0A0 + 12'(b0); req0_wdata = 16'hA0A0 + 16'(b0);
      req1_valid = (b1 < 1); req1_we = 1'b0; req1_lock = 1'b0; req1_addr = 12'h0F0;
      #1;
      exp_r0  = (c < 2) || (c >= 5 && c <= 7);
      exp_r1  = (c == 8);
      exp_v1  = (c == 10);
      exp_own = (c >= 1 && c <= 7) ? 2'b01 : 2'b00;
      tests_run++;
      if (req0_ready !== exp_r0 || req1_ready !== exp_r1 || owner !== exp_own) begin
        fail_count++;
        $display("[TB] FAIL gap_c%0d: got r0=%b r1=%b own=%b expected r0=%b r1=%b own=%b",
                 c, req0_ready, req1_ready, owner, exp_r0, exp_r1, exp_own);
      end
      tests_run++;
      if (rsp1_valid !== exp_v1 || (exp_v1 && rsp1_rdata !== 16'hC0F0)) begin
        fail_count++;
        $display("[TB] FAIL gap_rsp_c%0d: got rv1=%b rd1=%h expected rv1=%b rd1=c0f0",
                 c, rsp1_valid, rsp1_rdata, exp_v1);
      end
      if (req0_ready) b0++;
      if (req1_ready) b1++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_interleaved();
    int b0, b1;
    logic exp_r0, exp_r1, exp_v0, exp_v1;
    logic [15:0] exp_d;
    b0 = 0; b1 = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req0_valid = (b0 < 2); req0_we = 1'b0; req0_lock = 1'b0;
      req0_addr = (b0 == 0) ? 12'h010 : 12'h012;
      req1_valid = (b1 < 1); req1_we = 1'b0; req1_lock = 1'b0; req1_addr = 12'h011;
      #1;
      exp_r0 = (c == 0) || (c == 2);
      exp_r1 = (c == 1);
      exp_v0 = (c == 2) || (c == 4);
      exp_v1 = (c == 3);
      exp_d  = (c == 2) ? 16'hC010 : (c == 3) ? 16'hC011 : 16'hC012;
      tests_run++;
      if (req0_ready !== exp_r0 || req1_ready !== exp_r1 || rsp0_valid !== exp_v0 || rsp1_valid !== exp_v1) begin
        fail_count++;
        $display("[TB] FAIL intl_c%0d: got r0=%b r1=%b rv0=%b rv1=%b expected %b %b %b %b",
                 c, req0_ready, req1_ready, rsp0_valid, rsp1_valid, exp_r0, exp_r1, exp_v0, exp_v1);
      end
      if (exp_v0 || exp_v1) begin
        tests_run++;
        if ((exp_v0 ? rsp0_rdata : rsp1_rdata) !== exp_d) begin
          fail_count++;
          $display("[TB] FAIL intl_data_c%0d: got %h expected %h",
                   c, exp_v0 ? rsp0_rdata : rsp1_rdata, exp_d);
        end
      end
      if (req0_ready) b0++;
      if (req1_ready) b1++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h033;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL mid_accept: got r0=%b expected 1", req0_ready);
    end
    tick();
    clear_inputs();
    req1_valid = 1'b1; req1_lock = 1'b1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, sram_write_enable, owner} !== 7'b0 ||
        sram_read_address !== 12'h000 || rsp0_rdata !== 16'h0000) begin
      fail_count++;
      $display("[TB] FAIL mid_reset_outputs: got r0=%b r1=%b rv0=%b rv1=%b we=%b own=%b ra=%h rd0=%h expected all zero",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, sram_write_enable, owner,
               sram_read_address, rsp0_rdata);
    end
    tick();
    clear_inputs();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        fail_count++;
        $display("[TB] FAIL mid_no_rsp%0d: got rv0=%b rv1=%b expected 0 0", i, rsp0_valid, rsp1_valid);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_burst_preempt();
    test_gap();
    test_interleaved();
    test_reset_mid();
    tests_run++;
    if (proto_viol !== 0) begin
      fail_count++;
      $display("[TB] FAIL protocol: got %0d violations expected 0", proto_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
